kf_dma_request_arbiter: RTL and testbench
=========================================

Name: kf_dma_request_arbiter

Overview:
Parametrised DMA request arbiter, successor to the fixed 4-channel 8237 priority logic. It handles CHANNELS request lines with mask, software-request and edge-sense support. Unlike its predecessor, it owns its rotating-priority pointer and holds a registered grant through a grant/service_done handshake. It sits between the DREQ pins and the DMA timing/control FSM.

Parameters:
CHANNELS, 4, number of DMA channels (2..16)
SEL_W, $clog2(CHANNELS), channel index width (derived, not overridden)

Ports:
clock  in  1  system clock; all registers update on its falling edge
reset  in  1  asynchronous, active-high
master_clear  in  1  software master clear
write_command  in  1  load command fields from command_data
command_data  in  8  bit2 controller_disable, bit4 rotating_priority, bit6 dreq_active_low
set_reset_mask  in  1  single-channel mask write
mask_select  in  SEL_W  channel for set_reset_mask
mask_value  in  1  new mask bit
write_all_mask  in  1  load all mask bits
all_mask_data  in  CHANNELS  mask image
clear_mask  in  1  clear-mask command (sets all masks, clears request register)
write_request  in  1  software request write
request_select  in  SEL_W  channel for write_request
request_value  in  1  software request bit
edge_request  in  CHANNELS  per-channel edge-sense (1) vs level-sense (0)
dma_request  in  CHANNELS  raw DREQ pins
service_done  in  1  control FSM finished the current grant
end_of_process  in  1  qualifies service_done as terminal count/EOP
request_state  out  CHANNELS  effective pending requests
grant_valid  out  1  grant held
grant_onehot  out  CHANNELS  one-hot granted channel, 0 when not valid
grant_index  out  SEL_W  granted channel index
rotate_pointer  out  SEL_W  current highest-priority channel

Behaviour:
- Reset or master_clear: disable/rotating/active_low=0; mask all 1; request register 0; dreq_ff 0; locks 0; rotate_pointer 0; FSM IDLE; grant outputs 0. master_clear overrides every same-edge write.
- dreq_ff <= dma_request XOR {CHANNELS{dreq_active_low}} each falling edge.
- request_state (combinational) = (dreq_ff & ~lock & ~mask) | request_reg.
- Mask: clear_mask > set_reset_mask > write_all_mask > hold. mask_select >= CHANNELS is ignored.
- Request register: clear_mask clears all. Otherwise write_request on the selected bit wins; else a bit clears on service_done & end_of_process for the granted channel. request_select >= CHANNELS is ignored.
- Lock[i]: cleared if !edge_request[i]. Otherwise set when the grant to i is issued. Otherwise cleared when !dreq_ff[i] and i is not granted. Otherwise held.
- Priority:
  - fixed: channel 0 highest.
  - rotating: rotate_pointer highest, ascending index with wrap modulo CHANNELS.
- FSM IDLE:
  - If !controller_disable and request_state != 0, register the winner into grant_index/grant_onehot, set grant_valid, and go to GRANTED.
  - Latency: DREQ sampled at edge k, grant_valid high after edge k+1.
- FSM GRANTED:
  - Grant held regardless of later mask, disable or DREQ changes.
  - On service_done: clear grant, return to IDLE. If rotating, rotate_pointer <= (grant_index+1) mod CHANNELS. No re-grant on the same edge; the earliest new grant is the next edge.
- service_done in IDLE: ignored.
- write_command while GRANTED: takes effect for the next arbitration only.

Decomposition:
- Shared package kf_dma_pkg: command bit-position constants, arb_state_t enum {IDLE, GRANTED}, parametrised functions rotate_right/rotate_left/lowest_set_onehot.
- One sub-module: kf_dma_rr_select (combinational: requests + pointer + mode -> onehot/index/any).

Test Plan:
- CHANNELS=4, masks cleared, dma_request=4'b0110 fixed mode -> grant_index=1 two edges later; service_done -> IDLE, then grant_index=2.
- Rotating mode, requests 4'b1111 held, four service_done cycles -> grants 0,1,2,3 and rotate_pointer 1,2,3,0.
- Edge-sense ch2, DREQ2 held high across service_done -> no re-grant until DREQ2 drops one edge and rises again.
- write_request ch3=1 with mask=4'b1111 -> grant_index=3; service_done with end_of_process -> request_state[3]=0.
- Controller_disable set while GRANTED -> grant held until service_done; no new grant while disabled despite requests.
- CHANNELS=8, rotate_pointer=6, requests 8'b0010_0001 -> grant_index=0. Asserting master_clear mid-grant drops grant_valid at that edge.

Source files
------------

// File: rtl/kf_dma_pkg.sv
// Shared definitions for the DMA request arbiter: command bit positions, FSM state
// type and channel-vector helpers sized for the largest supported channel count.
package kf_dma_pkg;

  localparam int unsigned KF_MAX_CHANNELS = 16;

  localparam int unsigned CMD_DISABLE_BIT    = 2;
  localparam int unsigned CMD_ROTATING_BIT   = 4;
  localparam int unsigned CMD_ACTIVE_LOW_BIT = 6;

  typedef enum logic [0:0] {IDLE, GRANTED} arb_state_t;

  typedef logic [KF_MAX_CHANNELS-1:0] chan_vec_t;

  // Result bit i takes source bit (i + amt) mod n; bits at or above n read as zero.
  function automatic chan_vec_t rotate_right(chan_vec_t v, int unsigned amt, int unsigned n);
    chan_vec_t r;
    r = '0;
    for (int unsigned i = 0; i < KF_MAX_CHANNELS; i++) begin
      if (i < n) r[i] = v[(i + amt) % n];
    end
    return r;
  endfunction

  function automatic chan_vec_t rotate_left(chan_vec_t v, int unsigned amt, int unsigned n);
    chan_vec_t r;
    r = '0;
    for (int unsigned i = 0; i < KF_MAX_CHANNELS; i++) begin
      if (i < n) r[(i + amt) % n] = v[i];
    end
    return r;
  endfunction

  function automatic chan_vec_t lowest_set_onehot(chan_vec_t v);
    return v & (~v + chan_vec_t'(1));
  endfunction

endpackage

// File: rtl/kf_dma_request_arbiter_if.sv
// Handshake and register-write bundle between the CPU/DREQ side and the DMA request arbiter.
interface kf_dma_request_arbiter_if #(
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned SEL_W = $clog2(CHANNELS);

  logic                master_clear;
  logic                write_command;
  logic [7:0]          command_data;
  logic                set_reset_mask;
  logic [SEL_W-1:0]    mask_select;
  logic                mask_value;
  logic                write_all_mask;
  logic [CHANNELS-1:0] all_mask_data;
  logic                clear_mask;
  logic                write_request;
  logic [SEL_W-1:0]    request_select;
  logic                request_value;
  logic [CHANNELS-1:0] edge_request;
  logic [CHANNELS-1:0] dma_request;
  logic                service_done;
  logic                end_of_process;
  logic [CHANNELS-1:0] request_state;
  logic                grant_valid;
  logic [CHANNELS-1:0] grant_onehot;
  logic [SEL_W-1:0]    grant_index;
  logic [SEL_W-1:0]    rotate_pointer;

  modport master (
    output master_clear, write_command, command_data, set_reset_mask, mask_select, mask_value,
           write_all_mask, all_mask_data, clear_mask, write_request, request_select,
           request_value, edge_request, dma_request, service_done, end_of_process,
    input  request_state, grant_valid, grant_onehot, grant_index, rotate_pointer
  );

  modport slave (
    input  master_clear, write_command, command_data, set_reset_mask, mask_select, mask_value,
           write_all_mask, all_mask_data, clear_mask, write_request, request_select,
           request_value, edge_request, dma_request, service_done, end_of_process,
    output request_state, grant_valid, grant_onehot, grant_index, rotate_pointer
  );

endinterface

// File: rtl/kf_dma_rr_select.sv
// Combinational winner selection: fixed (channel 0 first) or rotating (pointer first,
// ascending with wrap) priority over the pending request vector.
module kf_dma_rr_select
  import kf_dma_pkg::*;
#(
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] i_request,
  input  logic [SEL_W-1:0]    i_pointer,
  input  logic                i_rotating,
  output logic [CHANNELS-1:0] o_onehot,
  output logic [SEL_W-1:0]    o_index,
  output logic                o_any
);

  logic [SEL_W-1:0] w_base;
  chan_vec_t        w_rel_onehot;

  assign w_base = i_rotating ? i_pointer : '0;

  // Rotate so the highest-priority channel lands on bit 0, pick the lowest, rotate back.
  assign w_rel_onehot = lowest_set_onehot(rotate_right(chan_vec_t'(i_request), 32'(w_base),
                                                       CHANNELS));
  assign o_onehot     = CHANNELS'(rotate_left(w_rel_onehot, 32'(w_base), CHANNELS));
  assign o_any        = |i_request;

  always_comb begin
    o_index = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (o_onehot[i]) o_index = SEL_W'(i);
    end
  end

endmodule

// File: rtl/kf_dma_request_arbiter.sv
// DMA request arbiter: DREQ sampling with polarity/edge-sense, mask and software requests,
// and a registered grant held until the control FSM reports service_done.
module kf_dma_request_arbiter
  import kf_dma_pkg::*;
#(
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input logic                    clock,
  input logic                    reset,
  kf_dma_request_arbiter_if.slave bus
);

  logic                r_disable;
  logic                r_rotating;
  logic                r_active_low;
  logic [CHANNELS-1:0] r_mask;
  logic [CHANNELS-1:0] r_request;
  logic [CHANNELS-1:0] r_dreq;
  logic [CHANNELS-1:0] r_lock;

  arb_state_t          r_state;
  logic                r_grant_valid;
  logic [CHANNELS-1:0] r_grant_onehot;
  logic [SEL_W-1:0]    r_grant_index;
  logic [SEL_W-1:0]    r_pointer;

  logic [CHANNELS-1:0] w_request_state;
  logic [CHANNELS-1:0] w_win_onehot;
  logic [SEL_W-1:0]    w_win_index;
  logic                w_win_any;
  logic                w_issue;
  logic                w_done;
  logic                w_mask_sel_ok;
  logic [CHANNELS-1:0] w_mask_d;
  logic [CHANNELS-1:0] w_request_d;
  logic [CHANNELS-1:0] w_lock_d;
  logic                unused_command_bits;

  assign unused_command_bits = ^bus.command_data;

  assign w_request_state = (r_dreq & ~r_lock & ~r_mask) | r_request;

  kf_dma_rr_select #(
    .CHANNELS (CHANNELS)
  ) u_rr_select (
    .i_request  (w_request_state),
    .i_pointer  (r_pointer),
    .i_rotating (r_rotating),
    .o_onehot   (w_win_onehot),
    .o_index    (w_win_index),
    .o_any      (w_win_any)
  );

  assign w_issue       = (r_state == IDLE) && !r_disable && w_win_any;
  assign w_done        = (r_state == GRANTED) && bus.service_done;
  assign w_mask_sel_ok = 32'(bus.mask_select) < CHANNELS;

  always_comb begin
    w_mask_d = r_mask;
    if (bus.clear_mask) begin
      w_mask_d = '1;
    end else if (bus.set_reset_mask && w_mask_sel_ok) begin
      w_mask_d[bus.mask_select] = bus.mask_value;
    end else if (bus.write_all_mask) begin
      w_mask_d = bus.all_mask_data;
    end
  end

  always_comb begin
    w_request_d = r_request;
    w_lock_d    = r_lock;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (bus.clear_mask) begin
        w_request_d[i] = 1'b0;
      end else if (bus.write_request && (32'(bus.request_select) == i)) begin
        w_request_d[i] = bus.request_value;
      end else if (w_done && bus.end_of_process && r_grant_onehot[i]) begin
        w_request_d[i] = 1'b0;
      end

      // Edge-sense channels stay locked after a grant until their DREQ is seen low.
      if (!bus.edge_request[i]) begin
        w_lock_d[i] = 1'b0;
      end else if (w_issue && w_win_onehot[i]) begin
        w_lock_d[i] = 1'b1;
      end else if (!r_dreq[i] && !r_grant_onehot[i]) begin
        w_lock_d[i] = 1'b0;
      end
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      r_disable    <= 1'b0;
      r_rotating   <= 1'b0;
      r_active_low <= 1'b0;
      r_mask       <= '1;
      r_request    <= '0;
      r_dreq       <= '0;
      r_lock       <= '0;
    end else if (bus.master_clear) begin
      r_disable    <= 1'b0;
      r_rotating   <= 1'b0;
      r_active_low <= 1'b0;
      r_mask       <= '1;
      r_request    <= '0;
      r_dreq       <= '0;
      r_lock       <= '0;
    end else begin
      if (bus.write_command) begin
        r_disable    <= bus.command_data[CMD_DISABLE_BIT];
        r_rotating   <= bus.command_data[CMD_ROTATING_BIT];
        r_active_low <= bus.command_data[CMD_ACTIVE_LOW_BIT];
      end
      r_mask    <= w_mask_d;
      r_request <= w_request_d;
      r_dreq    <= bus.dma_request ^ {CHANNELS{r_active_low}};
      r_lock    <= w_lock_d;
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_grant_valid  <= 1'b0;
      r_grant_onehot <= '0;
      r_grant_index  <= '0;
      r_pointer      <= '0;
    end else if (bus.master_clear) begin
      r_state        <= IDLE;
      r_grant_valid  <= 1'b0;
      r_grant_onehot <= '0;
      r_grant_index  <= '0;
      r_pointer      <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state        <= GRANTED;
            r_grant_valid  <= 1'b1;
            r_grant_onehot <= w_win_onehot;
            r_grant_index  <= w_win_index;
          end
        end
        GRANTED: begin
          if (bus.service_done) begin
            r_state        <= IDLE;
            r_grant_valid  <= 1'b0;
            r_grant_onehot <= '0;
            r_grant_index  <= '0;
            if (r_rotating) begin
              r_pointer <= SEL_W'((32'(r_grant_index) + 32'd1) % CHANNELS);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.request_state  = w_request_state;
  assign bus.grant_valid    = r_grant_valid;
  assign bus.grant_onehot   = r_grant_onehot;
  assign bus.grant_index    = r_grant_index;
  assign bus.rotate_pointer = r_pointer;

endmodule

// File: tb/tb_kf_dma_request_arbiter.sv
// Bench for the DMA request arbiter: directed scenarios plus randomized traffic on a
// 4-channel instance checked against a behavioural model, and a directed 8-channel case.
module tb_kf_dma_request_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  kf_dma_request_arbiter_if #(.CHANNELS(4)) bus4 ();
  kf_dma_request_arbiter_if #(.CHANNELS(8)) bus8 ();

  kf_dma_request_arbiter #(.CHANNELS(4)) dut4 (.clock(clock), .reset(reset), .bus(bus4.slave));
  kf_dma_request_arbiter #(.CHANNELS(8)) dut8 (.clock(clock), .reset(reset), .bus(bus8.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model of the 4-channel instance
  bit       m_dis, m_rot, m_al, m_granted;
  bit [3:0] m_mask, m_req, m_dreq, m_lock;
  int       m_ptr, m_gidx;

  function automatic bit [3:0] m_rs();
    return (m_dreq & ~m_lock & ~m_mask) | m_req;
  endfunction

  function automatic int winner(bit [3:0] rs, int base);
    for (int k = 0; k < 4; k++) begin
      if (rs[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_dis = 0; m_rot = 0; m_al = 0; m_granted = 0;
    m_mask = 4'hF; m_req = 0; m_dreq = 0; m_lock = 0; m_ptr = 0; m_gidx = 0;
  endtask

  task automatic model_step();
    bit [3:0] rs, nmask, nreq, nlock;
    int       w;
    bit       issue, done;
    if (reset || bus4.master_clear) begin
      model_reset();
      return;
    end
    rs    = m_rs();
    w     = winner(rs, m_rot ? m_ptr : 0);
    issue = !m_granted && !m_dis && (w >= 0);
    done  = m_granted && bus4.service_done;
    nmask = m_mask;
    if (bus4.clear_mask) nmask = 4'hF;
    else if (bus4.set_reset_mask) nmask[bus4.mask_select] = bus4.mask_value;
    else if (bus4.write_all_mask) nmask = bus4.all_mask_data;
    nreq  = m_req;
    nlock = m_lock;
    for (int i = 0; i < 4; i++) begin
      if (bus4.clear_mask) nreq[i] = 0;
      else if (bus4.write_request && int'(bus4.request_select) == i) nreq[i] = bus4.request_value;
      else if (done && bus4.end_of_process && m_gidx == i) nreq[i] = 0;
      if (!bus4.edge_request[i]) nlock[i] = 0;
      else if (issue && w == i) nlock[i] = 1;
      else if (!m_dreq[i] && !(m_granted && m_gidx == i)) nlock[i] = 0;
    end
    m_mask = nmask;
    m_req  = nreq;
    m_lock = nlock;
    m_dreq = bus4.dma_request ^ {4{m_al}};
    if (issue) begin
      m_granted = 1;
      m_gidx    = w;
    end else if (done) begin
      m_granted = 0;
      if (m_rot) m_ptr = (m_gidx + 1) % 4;
    end
    if (bus4.write_command) begin
      m_dis = bus4.command_data[2];
      m_rot = bus4.command_data[4];
      m_al  = bus4.command_data[6];
    end
  endtask

  task automatic check_model();
    check_eq("m_request_state", 32'(bus4.request_state), 32'(m_rs()));
    check_eq("m_grant_valid", 32'(bus4.grant_valid), 32'(m_granted));
    check_eq("m_grant_onehot", 32'(bus4.grant_onehot), m_granted ? (32'd1 << m_gidx) : 32'd0);
    check_eq("m_grant_index", 32'(bus4.grant_index), m_granted ? 32'(m_gidx) : 32'd0);
    check_eq("m_rotate_pointer", 32'(bus4.rotate_pointer), 32'(m_ptr));
  endtask

  // Inputs are applied just after a rising edge; the DUT updates on the falling edge.
  task automatic tick();
    model_step();
    @(negedge clock);
    @(posedge clock);
    check_model();
  endtask

  task automatic clear_pulses();
    bus4.master_clear = 0; bus4.write_command = 0; bus4.set_reset_mask = 0;
    bus4.write_all_mask = 0; bus4.clear_mask = 0; bus4.write_request = 0;
    bus4.service_done = 0; bus4.end_of_process = 0;
    bus8.master_clear = 0; bus8.write_command = 0; bus8.set_reset_mask = 0;
    bus8.write_all_mask = 0; bus8.clear_mask = 0; bus8.write_request = 0;
    bus8.service_done = 0; bus8.end_of_process = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_pulses();
    bus4.command_data = 0; bus4.mask_select = 0; bus4.mask_value = 0; bus4.all_mask_data = 0;
    bus4.request_select = 0; bus4.request_value = 0; bus4.edge_request = 0; bus4.dma_request = 0;
    bus8.command_data = 0; bus8.mask_select = 0; bus8.mask_value = 0; bus8.all_mask_data = 0;
    bus8.request_select = 0; bus8.request_value = 0; bus8.edge_request = 0; bus8.dma_request = 0;
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
    // Fixed priority, level-sensed
    do_reset();
    check_eq("rst_grant_valid", 32'(bus4.grant_valid), 0);
    check_eq("rst_request_state", 32'(bus4.request_state), 0);
    check_eq("rst_rotate_pointer", 32'(bus4.rotate_pointer), 0);
    bus4.write_all_mask = 1; bus4.all_mask_data = 4'b0000; bus4.dma_request = 4'b0110;
    tick(); clear_pulses(); tick();
    check_eq("fixed_valid", 32'(bus4.grant_valid), 1);
    check_eq("fixed_index", 32'(bus4.grant_index), 1);
    bus4.service_done = 1; bus4.dma_request = 4'b0100;
    tick(); clear_pulses();
    check_eq("fixed_done_valid", 32'(bus4.grant_valid), 0);
    tick();
    check_eq("fixed_next_index", 32'(bus4.grant_index), 2);

    // Rotating priority with all requests held
    do_reset();
    bus4.write_all_mask = 1; bus4.all_mask_data = 0;
    bus4.write_command = 1; bus4.command_data = 8'h10; bus4.dma_request = 4'b1111;
    tick(); clear_pulses(); tick();
    for (int g = 0; g < 4; g++) begin
      check_eq("rot_index", 32'(bus4.grant_index), 32'(g));
      bus4.service_done = 1;
      tick(); clear_pulses();
      check_eq("rot_pointer", 32'(bus4.rotate_pointer), 32'((g + 1) % 4));
      tick();
    end

    // Edge-sense channel 2
    do_reset();
    bus4.write_all_mask = 1; bus4.all_mask_data = 0;
    bus4.edge_request = 4'b0100; bus4.dma_request = 4'b0100;
    tick(); clear_pulses(); tick();
    check_eq("edge_first_index", 32'(bus4.grant_index), 2);
    bus4.service_done = 1;
    tick(); clear_pulses(); tick(); tick();
    check_eq("edge_no_regrant", 32'(bus4.grant_valid), 0);
    check_eq("edge_locked_rs", 32'(bus4.request_state), 0);
    bus4.dma_request = 4'b0000; tick();
    bus4.dma_request = 4'b0100; tick(); tick();
    check_eq("edge_regrant_valid", 32'(bus4.grant_valid), 1);
    check_eq("edge_regrant_index", 32'(bus4.grant_index), 2);

    // Software request overrides mask; cleared by end of process
    do_reset();
    bus4.write_request = 1; bus4.request_select = 3; bus4.request_value = 1;
    tick(); clear_pulses(); tick();
    check_eq("sw_index", 32'(bus4.grant_index), 3);
    bus4.service_done = 1; bus4.end_of_process = 1;
    tick(); clear_pulses();
    check_eq("sw_eop_rs", 32'(bus4.request_state), 0);

    // Disable while granted
    do_reset();
    bus4.write_all_mask = 1; bus4.all_mask_data = 0; bus4.dma_request = 4'b0011;
    tick(); clear_pulses(); tick();
    check_eq("dis_index", 32'(bus4.grant_index), 0);
    bus4.write_command = 1; bus4.command_data = 8'h04;
    tick(); clear_pulses(); tick();
    check_eq("dis_hold", 32'(bus4.grant_valid), 1);
    bus4.service_done = 1;
    tick(); clear_pulses(); tick(); tick();
    check_eq("dis_no_grant", 32'(bus4.grant_valid), 0);
    check_eq("dis_rs", 32'(bus4.request_state), 4'b0011);

    // 8 channels: pointer reaches 6, wrap to channel 0, then master clear mid-grant
    do_reset();
    bus8.write_all_mask = 1; bus8.all_mask_data = 0;
    bus8.write_command = 1; bus8.command_data = 8'h10;
    bus8.write_request = 1; bus8.request_select = 5; bus8.request_value = 1;
    tick(); clear_pulses(); tick();
    check_eq("ch8_first_index", 32'(bus8.grant_index), 5);
    bus8.service_done = 1; bus8.end_of_process = 1;
    tick(); clear_pulses();
    check_eq("ch8_pointer", 32'(bus8.rotate_pointer), 6);
    bus8.dma_request = 8'b0010_0001;
    tick(); tick();
    check_eq("ch8_wrap_valid", 32'(bus8.grant_valid), 1);
    check_eq("ch8_wrap_index", 32'(bus8.grant_index), 0);
    bus8.master_clear = 1;
    tick(); clear_pulses();
    check_eq("ch8_mclr_valid", 32'(bus8.grant_valid), 0);
    check_eq("ch8_mclr_onehot", 32'(bus8.grant_onehot), 0);
    check_eq("ch8_mclr_pointer", 32'(bus8.rotate_pointer), 0);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bus4.master_clear   = ($urandom_range(0, 99) == 0);
      bus4.write_command  = ($urandom_range(0, 15) == 0);
      bus4.command_data   = 8'($urandom);
      if ($urandom_range(0, 3) != 0) bus4.command_data[2] = 1'b0;
      bus4.set_reset_mask = ($urandom_range(0, 7) == 0);
      bus4.mask_select    = 2'($urandom);
      bus4.mask_value     = 1'($urandom);
      bus4.write_all_mask = ($urandom_range(0, 15) == 0);
      bus4.all_mask_data  = 4'($urandom & $urandom);
      bus4.clear_mask     = ($urandom_range(0, 63) == 0);
      bus4.write_request  = ($urandom_range(0, 11) == 0);
      bus4.request_select = 2'($urandom);
      bus4.request_value  = 1'($urandom);
      if ($urandom_range(0, 31) == 0) bus4.edge_request = 4'($urandom);
      if ($urandom_range(0, 3) == 0) bus4.dma_request = 4'($urandom);
      bus4.service_done   = ($urandom_range(0, 2) == 0);
      bus4.end_of_process = 1'($urandom);
      tick();
      clear_pulses();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
